// File: rtl/i2s_rx.sv
// I2S slave receiver: syncs BCLK/LRCK/DATA into clk, deframes L/R words and presents stereo pairs.
// Pair valid SYNC_STAGES+3 clk after the last right bit is sampled; an unaccepted pair is overwritten and flagged.
module i2s_rx #(
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i2s_bclk,
    input  logic              i2s_lrck,
    input  logic              i2s_data,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              overrun_out,
    output logic              frame_err_out
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {HUNT, LEFT, RIGHT} state_t;

    logic [SYNC_STAGES-1:0] r_bclk_sync;
    logic [SYNC_STAGES-1:0] r_lrck_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_bclk_prev;
    logic                   r_rise;
    logic                   r_lrck_q;
    logic                   r_data_q;
    logic                   r_lrck_prev;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [DATA_W-1:0]      r_shift;
    logic [DATA_W-1:0]      r_left_hold;
    logic [DATA_W-1:0]      r_right_hold;
    logic                   r_left_ok;
    logic                   r_commit;

    logic                   w_bclk_s;
    logic                   w_lrck_s;
    logic                   w_data_s;
    logic                   w_boundary;
    logic                   w_clear;
    logic                   w_shift_en;
    logic                   w_word_done;
    logic                   w_frame_err;
    logic [DATA_W-1:0]      w_shift_nxt;

    assign w_bclk_s    = r_bclk_sync[SYNC_STAGES-1];
    assign w_lrck_s    = r_lrck_sync[SYNC_STAGES-1];
    assign w_data_s    = r_data_sync[SYNC_STAGES-1];
    assign w_boundary  = (r_lrck_q != r_lrck_prev);
    assign w_shift_nxt = {r_shift[DATA_W-2:0], r_data_q};

    // Rise strobe is registered, so lrck/data are retimed with it to stay aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bclk_sync <= '0;
            r_lrck_sync <= '0;
            r_data_sync <= '0;
            r_bclk_prev <= 1'b0;
            r_rise      <= 1'b0;
            r_lrck_q    <= 1'b0;
            r_data_q    <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
            r_lrck_sync <= {r_lrck_sync[SYNC_STAGES-2:0], i2s_lrck};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], i2s_data};
            r_bclk_prev <= w_bclk_s;
            r_rise      <= w_bclk_s & ~r_bclk_prev;
            r_lrck_q    <= w_lrck_s;
            r_data_q    <= w_data_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift_en  = 1'b0;
        w_word_done = 1'b0;
        w_frame_err = 1'b0;
        if (r_rise) begin
            case (r_state)
                HUNT: begin
                    if (!r_lrck_q && r_lrck_prev) begin
                        w_state_nxt = LEFT;
                        w_clear     = 1'b1;
                    end
                end
                default: begin
                    if (w_boundary) begin
                        // This rise carries the previous slot's LSB, which is dropped.
                        w_clear     = 1'b1;
                        w_frame_err = (r_bit_cnt != CNT_FULL);
                        w_state_nxt = r_lrck_q ? RIGHT : LEFT;
                    end else if (r_bit_cnt != CNT_FULL) begin
                        w_shift_en  = 1'b1;
                        w_word_done = (r_bit_cnt == CNT_LAST);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lrck_prev   <= 1'b0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_left_hold   <= '0;
            r_right_hold  <= '0;
            r_left_ok     <= 1'b0;
            r_commit      <= 1'b0;
            frame_err_out <= 1'b0;
        end else begin
            r_commit      <= 1'b0;
            frame_err_out <= w_frame_err;
            if (r_rise) begin
                r_lrck_prev <= r_lrck_q;
            end
            if (w_clear) begin
                r_bit_cnt <= '0;
                r_shift   <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= w_shift_nxt;
            end
            if (w_frame_err) begin
                r_left_ok <= 1'b0;
            end
            if (w_word_done) begin
                if (r_state == LEFT) begin
                    r_left_hold <= w_shift_nxt;
                    r_left_ok   <= 1'b1;
                end else begin
                    r_right_hold <= w_shift_nxt;
                    if (r_left_ok) begin
                        r_commit  <= 1'b1;
                        r_left_ok <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            left_out    <= '0;
            right_out   <= '0;
            valid_out   <= 1'b0;
            overrun_out <= 1'b0;
        end else begin
            overrun_out <= 1'b0;
            if (r_commit) begin
                left_out    <= r_left_hold;
                right_out   <= r_right_hold;
                valid_out   <= 1'b1;
                overrun_out <= valid_out & ~ready_in;
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: drives Philips I2S slots and compares against a slot-level reference model.
module tb_i2s_rx;
    localparam int DATA_W = 16;
    localparam int SYNC   = 2;
    localparam int LAT    = SYNC + 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i2s_bclk = 1'b0;
    logic        i2s_lrck = 1'b0;
    logic        i2s_data = 1'b0;
    logic        ready_in = 1'b1;
    logic [15:0] left_out;
    logic [15:0] right_out;
    logic        valid_out;
    logic        overrun_out;
    logic        frame_err_out;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    i2s_rx #(.DATA_W(DATA_W), .SYNC_STAGES(SYNC)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .i2s_bclk     (i2s_bclk),
        .i2s_lrck     (i2s_lrck),
        .i2s_data     (i2s_data),
        .left_out     (left_out),
        .right_out    (right_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .overrun_out  (overrun_out),
        .frame_err_out(frame_err_out)
    );

    typedef struct {
        bit          lr;
        int          width;
        logic [15:0] word;
        bit          pad;
    } slot_t;

    slot_t       slots[$];
    logic [15:0] got_l[$];
    logic [15:0] got_r[$];
    int          vrise[$];
    int          rise_cyc[$];
    int          fe_cnt = 0;
    int          ov_cnt = 0;
    logic        v_prev = 1'b0;
    logic [15:0] exp_l[$];
    logic [15:0] exp_r[$];
    int          exp_fe;
    bit          rand_rdy = 1'b0;
    int          nvec = 0;
    int          nerr = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (valid_out && ready_in) begin
                got_l.push_back(left_out);
                got_r.push_back(right_out);
            end
            if (valid_out && !v_prev) vrise.push_back(cyc);
            if (overrun_out) ov_cnt <= ov_cnt + 1;
            if (frame_err_out) fe_cnt <= fe_cnt + 1;
        end
        v_prev <= valid_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_rdy) ready_in = 1'($urandom_range(0, 1));
    endtask

    task automatic add(input bit lr, input int w, input logic [15:0] word, input bit pad);
        slot_t s;
        s.lr = lr; s.width = w; s.word = word; s.pad = pad;
        slots.push_back(s);
    endtask

    task automatic add_frame(input logic [15:0] l, input logic [15:0] r, input int w, input bit pad);
        add(1'b0, w, l, pad);
        add(1'b1, w, r, pad);
    endtask

    // Data lags LRCK by one BCLK: each BCLK carries the previous slot bit.
    task automatic play(input int rst_lo, input int rst_hi);
        bit lrq[$];
        bit dq[$];
        bit prev = 1'b0;
        foreach (slots[s]) begin
            for (int i = 0; i < slots[s].width; i++) begin
                lrq.push_back(slots[s].lr);
                dq.push_back(prev);
                prev = (i < 16) ? slots[s].word[15-i] : slots[s].pad;
            end
        end
        rise_cyc.delete();
        for (int k = 0; k < lrq.size(); k++) begin
            tick();
            if (k == rst_lo) rst_n = 1'b0;
            if (k == rst_hi) rst_n = 1'b1;
            i2s_bclk = 1'b0;
            i2s_lrck = lrq[k];
            i2s_data = dq[k];
            repeat (4) tick();
            i2s_bclk = 1'b1;
            rise_cyc.push_back(cyc);
            repeat (3) tick();
        end
        tick();
        i2s_bclk = 1'b0;
    endtask

    // A slot yields width-1 bits; it completes once DATA_W of them arrive.
    task automatic model(input int start);
        bit          hunting = 1'b1;
        bit          left_ok = 1'b0;
        logic [15:0] lw = '0;
        exp_l.delete();
        exp_r.delete();
        exp_fe = 0;
        for (int i = start; i < slots.size(); i++) begin
            bit done;
            done = (slots[i].width - 1) >= DATA_W;
            if (hunting) begin
                if (i > start && slots[i].lr == 1'b0 && slots[i-1].lr == 1'b1) hunting = 1'b0;
                else continue;
            end
            if (slots[i].lr == 1'b0) begin
                if (done) begin left_ok = 1'b1; lw = slots[i].word; end
            end else if (done) begin
                if (left_ok) begin exp_l.push_back(lw); exp_r.push_back(slots[i].word); end
                left_ok = 1'b0;
            end
            if (!done && i + 1 < slots.size()) begin
                exp_fe++;
                left_ok = 1'b0;
            end
        end
    endtask

    task automatic run(input string tag, input int start, input int lo, input int hi, input bit rr);
        int gb = got_l.size();
        int fb = fe_cnt;
        int ob = ov_cnt;
        rand_rdy = rr;
        play(lo, hi);
        rand_rdy = 1'b0;
        ready_in = 1'b1;
        repeat (40) tick();
        model(start);
        chk($sformatf("%s pairs", tag), 32'(got_l.size() - gb), 32'(exp_l.size()));
        for (int i = 0; i < exp_l.size(); i++) begin
            if (gb + i < got_l.size()) begin
                chk($sformatf("%s left[%0d]", tag, i), 32'(got_l[gb+i]), 32'(exp_l[i]));
                chk($sformatf("%s right[%0d]", tag, i), 32'(got_r[gb+i]), 32'(exp_r[i]));
            end
        end
        chk($sformatf("%s frame_err", tag), 32'(fe_cnt - fb), 32'(exp_fe));
        chk($sformatf("%s overrun", tag), 32'(ov_cnt - ob), 32'd0);
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        slots.delete();
    endtask

    initial begin
        int vb, gb, ob;
        int wl[5] = '{17, 18, 20, 24, 32};

        repeat (3) tick();
        chk("reset left", 32'(left_out), 32'd0);
        chk("reset right", 32'(right_out), 32'd0);
        chk("reset valid", 32'(valid_out), 32'd0);
        chk("reset overrun", 32'(overrun_out), 32'd0);
        chk("reset frame_err", 32'(frame_err_out), 32'd0);
        rst_n = 1'b1;
        tick();

        add(1'b1, 32, 16'h0000, 1'b0);
        repeat (3) add_frame(16'h1234, 16'hABCD, 32, 1'b0);
        vb = vrise.size();
        run("basic", 0, -1, -1, 1'b0);
        chk("basic valid pulses", 32'(vrise.size() - vb), 32'd3);
        if (vrise.size() > vb && rise_cyc.size() > 80)
            chk("basic latency", 32'(vrise[vb] - rise_cyc[80]), 32'(LAT));

        do_reset();
        add(1'b1, 32, 16'h0000, 1'b1);
        repeat (2) add_frame(16'h8000, 16'h7FFF, 32, 1'b1);
        run("msb", 0, -1, -1, 1'b0);

        do_reset();
        rst_n = 1'b0;
        add_frame(16'hDEAD, 16'hBEEF, 32, 1'b0);
        add_frame(16'h1111, 16'h2222, 32, 1'b0);
        add_frame(16'h3333, 16'h4444, 32, 1'b0);
        run("startup", 1, -1, 42, 1'b0);

        do_reset();
        add(1'b1, 32, 16'h0000, 1'b0);
        for (int f = 0; f < 8; f++)
            add_frame(16'($urandom), 16'($urandom), wl[$urandom_range(0, 4)], 1'($urandom_range(0, 1)));
        run("random", 0, -1, -1, 1'b1);

        do_reset();
        add(1'b1, 32, 16'h0000, 1'b0);
        add_frame(16'h0101, 16'h0202, 32, 1'b0);
        add(1'b0, 10, 16'h5555, 1'b0);
        add(1'b1, 32, 16'h6666, 1'b0);
        add_frame(16'h0303, 16'h0404, 32, 1'b0);
        run("short", 0, -1, -1, 1'b0);

        do_reset();
        add(1'b1, 32, 16'h0000, 1'b0);
        add_frame(16'hA5A5, 16'h5A5A, 17, 1'b0);
        add(1'b0, 16, 16'hFFFF, 1'b1);
        add(1'b1, 32, 16'hEEEE, 1'b0);
        add_frame(16'h0F0F, 16'hF0F0, 20, 1'b1);
        run("width edge", 0, -1, -1, 1'b0);

        do_reset();
        add(1'b1, 17, 16'h0000, 1'b0);
        for (int k = 0; k < 16; k++) add_frame(16'(2 * k), 16'(2 * k + 1), 17, 1'b0);
        run("ramp", 0, -1, -1, 1'b0);

        do_reset();
        add(1'b1, 32, 16'h0000, 1'b0);
        add_frame(16'hC0DE, 16'hCAFE, 32, 1'b0);
        add_frame(16'h1357, 16'h2468, 32, 1'b0);
        add_frame(16'h9999, 16'h8888, 32, 1'b0);
        run("midreset", 2, 72, 76, 1'b0);

        do_reset();
        ready_in = 1'b0;
        add(1'b1, 32, 16'h0000, 1'b0);
        add_frame(16'd1, 16'd2, 32, 1'b0);
        add_frame(16'd3, 16'd4, 32, 1'b0);
        gb = got_l.size();
        ob = ov_cnt;
        play(-1, -1);
        repeat (40) tick();
        chk("bp valid held", 32'(valid_out), 32'd1);
        chk("bp left", 32'(left_out), 32'd3);
        chk("bp right", 32'(right_out), 32'd4);
        chk("bp overrun", 32'(ov_cnt - ob), 32'd1);
        ready_in = 1'b1;
        tick();
        chk("bp valid drop", 32'(valid_out), 32'd0);
        chk("bp accepted", 32'(got_l.size() - gb), 32'd1);
        if (got_l.size() > gb) chk("bp accepted left", 32'(got_l[gb]), 32'd3);

        do_reset();
        ready_in = 1'b0;
        add(1'b1, 32, 16'h0000, 1'b0);
        add_frame(16'd5, 16'd6, 32, 1'b0);
        play(-1, -1);
        repeat (40) tick();
        chk("async pre valid", 32'(valid_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async valid", 32'(valid_out), 32'd0);
        chk("async left", 32'(left_out), 32'd0);
        ready_in = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end
endmodule
